// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the sequential ALU datapath: opcode encoding,
//   FSM state encoding and a width helper for the shift-amount field.
//   Optional feature macro used by the top level: ALU_ACCUM_EN.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_XOR = 3'b010,
        OP_CMP = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_SHL = 3'b110,
        OP_ILL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of low bits of operand B used as the shift amount.
    function automatic int cmp_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Purely combinational operation unit. No state.
//   Ports:
//     op        in   3           operation select (op_t encoding)
//     a, b      in   DATA_WIDTH  operands
//     result    out  DATA_WIDTH  operation result (wrapping, unsigned)
//     overflow  out  1           ADD carry-out / SUB borrow-out, else 0
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int SH_W = cmp_width(DATA_WIDTH);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        // One extra bit holds the carry (ADD) or borrow (SUB).
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        result   = '0;
        overflow = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                result   = sum[DATA_WIDTH-1:0];
                overflow = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                result   = diff[DATA_WIDTH-1:0];
                overflow = diff[DATA_WIDTH];
            end
            OP_XOR:  result = a ^ b;
            OP_CMP:  result = {{(DATA_WIDTH-2){1'b0}}, (a > b), (a == b)};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SHL:  result = a << b[SH_W-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_datapath.sv
// alu_seq_datapath
//   Multi-cycle handshaked ALU. Operands A/B are loaded over alu_data, start
//   launches one operation that spends OP_LATENCY cycles in EXEC, and the
//   result is held in DONE until result_ack.
//   Optional feature: ALU_ACCUM_EN adds accum_sel; when set at start, the
//   last acknowledged result replaces the A register as operand A.
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     alu_data             operand bus
//     opcode_value         operation select, sampled with start
//     store_a / store_b    load alu_data into A / B (IDLE only)
//     start                launch operation (IDLE only)
//     result_ack           consumer accepts result (DONE only)
//     accum_sel            (ALU_ACCUM_EN only) use last result as operand A
//     busy                 state != IDLE
//     alu_done             result valid, held until ack
//     result, overflow, zero, illegal_op   registered result flags
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic [2:0]            opcode_value,
    input  logic                  store_a,
    input  logic                  store_b,
    input  logic                  start,
    input  logic                  result_ack,
`ifdef ALU_ACCUM_EN
    input  logic                  accum_sel,
`endif
    output logic                  busy,
    output logic                  alu_done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  zero,
    output logic                  illegal_op
);

    localparam int CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    // Operands and opcode frozen at start so the op is immune to later bus activity.
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   opa_q;
    logic [DATA_WIDTH-1:0]   opb_q;
    logic [DATA_WIDTH-1:0]   opa_sel;
    logic [DATA_WIDTH-1:0]   core_res;
    logic                    core_ovf;

`ifdef ALU_ACCUM_EN
    logic [DATA_WIDTH-1:0]   last_res;
    assign opa_sel = accum_sel ? last_res : a_reg;
`else
    assign opa_sel = a_reg;
`endif

    assign busy = (state != ST_IDLE);

    alu_seq_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .op       (op_q),
        .a        (opa_q),
        .b        (opb_q),
        .result   (core_res),
        .overflow (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            alu_done   <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
`ifdef ALU_ACCUM_EN
            last_res   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (store_a) begin
                        a_reg <= alu_data;
                    end else if (store_b) begin
                        b_reg <= alu_data;
                    end else if (start) begin
                        op_q  <= opcode_value;
                        opa_q <= opa_sel;
                        opb_q <= b_reg;
                        cnt   <= CNT_W'(OP_LATENCY - 1);
                        if (opcode_value == OP_ILL) begin
                            // Illegal opcode skips EXEC; result is 0, so zero follows it.
                            state      <= ST_DONE;
                            alu_done   <= 1'b1;
                            illegal_op <= 1'b1;
                            result     <= '0;
                            overflow   <= 1'b0;
                            zero       <= 1'b1;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        state    <= ST_DONE;
                        alu_done <= 1'b1;
                        result   <= core_res;
                        overflow <= core_ovf;
                        zero     <= (core_res == '0);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        state      <= ST_IDLE;
                        alu_done   <= 1'b0;
                        result     <= '0;
                        overflow   <= 1'b0;
                        zero       <= 1'b0;
                        illegal_op <= 1'b0;
`ifdef ALU_ACCUM_EN
                        last_res   <= result;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
